multiport_grf: RTL and testbench
================================

MULTIPORT_GRF -- requirements
Module: multiport_grf

Interface
REQ-001 Parameter DATA_W SHALL be provided: default 32, register width in bits.
REQ-002 Parameter ADDR_W SHALL be provided: default 5, register index width; REG_N = 2**ADDR_W registers.
REQ-003 Parameter NRD SHALL be provided: default 2, number of read ports, range 1..4.
REQ-004 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  reset; synchronous, active-high.
REQ-006 we0  input  1  write enable, port 0.
REQ-007 wa0  input  ADDR_W  write address, port 0.
REQ-008 wd0  input  DATA_W  write data, port 0.
REQ-009 we1, wa1, wd1  input  1/ADDR_W/DATA_W  write port 1, same meaning as port 0.
REQ-010 ra  input  NRD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
REQ-011 rd  output  NRD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W].
REQ-012 rbusy  output  NRD  scoreboard busy bit of each read-port address.
REQ-013 iss_en  input  1  issue strobe; marks iss_addr as pending-write.
REQ-014 iss_addr  input  ADDR_W  destination register of the issued instruction.
REQ-015 busy_cnt  output  ADDR_W+1  number of registers currently busy.

Function
REQ-016 Register 0 SHALL read as zero, ignore writes, and never become busy.
REQ-017 Reads SHALL be combinational: rd[k] = regs[ra[k]], zero-latency.
REQ-018 A write with weN=1 and waN!=0 SHALL update regs[waN] at the next rising edge.
REQ-019 When both ports write the same nonzero address in one cycle, port 1 data SHALL be stored.
REQ-020 Issue (iss_en=1, iss_addr!=0) SHALL set busy[iss_addr] at the next edge.
REQ-021 Any enabled write to a nonzero address SHALL clear its busy bit at the next edge; writing a non-busy register SHALL be legal and leave busy unchanged.
REQ-022 When issue and write target the same register in one cycle, issue SHALL win: the bit ends set.
REQ-023 busy_cnt SHALL be a registered counter updated by the net change per edge (+1 for each 0->1 bit, -1 for each 1->0 bit) and SHALL always equal popcount(busy).
REQ-024 Two write ports clearing the same busy register in one cycle SHALL decrement busy_cnt once.
REQ-025 rbusy[k] SHALL reflect the registered busy bit of ra[k], combinationally.
REQ-026 Out-of-range values SHALL NOT exist: every ADDR_W-bit address maps to a valid register.

Reset
REQ-027 reset=1 at a rising edge SHALL zero all registers, clear all busy bits and set busy_cnt=0.
REQ-028 Reset SHALL take priority over simultaneous writes and issues in the same cycle.
REQ-029 While reset is held, rd SHALL read zero from the edge after reset is first sampled, and rbusy SHALL be 0.

Configuration
REQ-030 Macro MULTIPORT_GRF_BYPASS_EN SHALL control write-to-read forwarding.
REQ-031 With MULTIPORT_GRF_BYPASS_EN defined, rd[k] SHALL return same-cycle write data when ra[k] matches an enabled nonzero write address (port 1 over port 0), and rbusy[k] SHALL read 0 for that address unless iss_addr also matches in that cycle.
REQ-032 Without MULTIPORT_GRF_BYPASS_EN, rd and rbusy SHALL show stored state only; new data is visible one cycle after the write edge.

Verification
REQ-033 Reset, then we0=1 wa0=5 wd0=0x1234 -> next cycle ra[0]=5 reads 0x1234; write to reg 0 reads 0.
REQ-034 we0 wa0=7 wd0=0xAAAA and we1 wa1=7 wd1=0x5555 in one cycle -> reg 7 reads 0x5555.
REQ-035 Issue regs 3, 4, 9 on three cycles -> busy_cnt 1, 2, 3; both ports write reg 4 in one cycle -> busy_cnt=2, rbusy for reg 4 = 0.
REQ-036 iss_addr=6 with we0 wa0=6 in the same cycle -> busy[6]=1, reg 6 updated, busy_cnt +1.
REQ-037 With bypass: we1 wa1=2 wd1=0xBEEF, ra[1]=2 same cycle -> rd[1]=0xBEEF; without bypass -> old value, then 0xBEEF next cycle.
REQ-038 Assert reset during writes and issues with busy_cnt=3 -> next edge all reads 0, busy_cnt=0, rbusy=0.

Source files
------------

// File: rtl/multiport_grf.sv
// multiport_grf: general register file with two write ports, NRD combinational
// read ports and a per-register busy scoreboard with a population counter.
//
// Optional feature (compile-time macro MULTIPORT_GRF_BYPASS_EN):
//   when defined, same-cycle write data is forwarded to matching read ports
//   and the forwarded address reads as not busy unless it is also being issued.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous, active-high reset
//   we0/wa0/wd0, we1/wa1/wd1   write ports (port 1 wins on same address)
//   ra        NRD packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd        NRD packed read data,      port k at [k*DATA_W +: DATA_W]
//   rbusy     busy bit of each read-port address
//   iss_en    issue strobe, marks iss_addr as pending-write
//   iss_addr  destination register of the issued instruction
//   busy_cnt  number of registers currently busy
module multiport_grf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we0,
  input  logic [ADDR_W-1:0]     wa0,
  input  logic [DATA_W-1:0]     wd0,
  input  logic                  we1,
  input  logic [ADDR_W-1:0]     wa1,
  input  logic [DATA_W-1:0]     wd1,
  input  logic [NRD*ADDR_W-1:0] ra,
  output logic [NRD*DATA_W-1:0] rd,
  output logic [NRD-1:0]        rbusy,
  input  logic                  iss_en,
  input  logic [ADDR_W-1:0]     iss_addr,
  output logic [ADDR_W:0]       busy_cnt
);

  localparam int REG_N = 2 ** ADDR_W;
  localparam int CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0] regs [REG_N];
  logic [REG_N-1:0]  busy;
  logic [REG_N-1:0]  busy_nxt;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_nxt;

  logic wr0, wr1, iss;
  logic inc, clr0, clr1;

  // Register 0 is never a write or issue target.
  assign wr0 = we0 && (wa0 != '0);
  assign wr1 = we1 && (wa1 != '0);
  assign iss = iss_en && (iss_addr != '0);

  // Clears first, then issue, so an issue to a register being written wins.
  always_comb begin
    busy_nxt = busy;
    if (wr0) busy_nxt[wa0] = 1'b0;
    if (wr1) busy_nxt[wa1] = 1'b0;
    if (iss) busy_nxt[iss_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Net-change counter: each bit transition is counted exactly once, so a
  // register cleared by both write ports decrements only through clr0.
  always_comb begin
    inc  = iss && !busy[iss_addr];
    clr0 = wr0 && busy[wa0] && !(iss && (iss_addr == wa0));
    clr1 = wr1 && busy[wa1] && !(iss && (iss_addr == wa1))
               && !(wr0 && (wa0 == wa1));
    cnt_nxt = cnt_q + {{(CNT_W-1){1'b0}}, inc}
                    - {{(CNT_W-1){1'b0}}, clr0}
                    - {{(CNT_W-1){1'b0}}, clr1};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < REG_N; i++) regs[i] <= '0;
      busy  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr0) regs[wa0] <= wd0;
      if (wr1) regs[wa1] <= wd1;
      busy  <= busy_nxt;
      cnt_q <= cnt_nxt;
    end
  end

  assign busy_cnt = cnt_q;

  always_comb begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              b;
    rd    = '0;
    rbusy = '0;
    for (int unsigned k = 0; k < NRD; k++) begin
      a = ra[k*ADDR_W +: ADDR_W];
      d = (a == '0) ? '0 : regs[a];
      b = busy[a];
`ifdef MULTIPORT_GRF_BYPASS_EN
      // Forwarding is suppressed under reset so reads stay zero while held.
      if (!reset) begin
        if (wr0 && (wa0 == a)) begin
          d = wd0;
          b = iss && (iss_addr == a);
        end
        if (wr1 && (wa1 == a)) begin
          d = wd1;
          b = iss && (iss_addr == a);
        end
      end
`endif
      rd[k*DATA_W +: DATA_W] = d;
      rbusy[k]               = b;
    end
  end

endmodule

// File: tb/tb_multiport_grf.sv
module tb_multiport_grf;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NRD    = 2;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  we0, we1, iss_en;
  logic [ADDR_W-1:0]     wa0, wa1, iss_addr;
  logic [DATA_W-1:0]     wd0, wd1;
  logic [NRD*ADDR_W-1:0] ra;
  logic [NRD*DATA_W-1:0] rd;
  logic [NRD-1:0]        rbusy;
  logic [ADDR_W:0]       busy_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multiport_grf #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NRD(NRD)) dut (
    .clk(clk), .reset(reset),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra(ra), .rd(rd), .rbusy(rbusy),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .busy_cnt(busy_cnt)
  );

  typedef struct {
    logic        rst;
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        iss;
    logic [4:0]  ia;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] rd0;
    logic [31:0] rd1;
    logic [1:0]  rb;
    logic [5:0]  cnt;
  } vec_t;

  function automatic vec_t mkv(
    input logic rst_i, input logic we0_i, input logic [4:0] wa0_i, input logic [31:0] wd0_i,
    input logic we1_i, input logic [4:0] wa1_i, input logic [31:0] wd1_i,
    input logic iss_i, input logic [4:0] ia_i, input logic [4:0] ra0_i, input logic [4:0] ra1_i,
    input logic [31:0] rd0_i, input logic [31:0] rd1_i, input logic [1:0] rb_i, input logic [5:0] cnt_i);
    vec_t v;
    v.rst = rst_i; v.we0 = we0_i; v.wa0 = wa0_i; v.wd0 = wd0_i;
    v.we1 = we1_i; v.wa1 = wa1_i; v.wd1 = wd1_i; v.iss = iss_i; v.ia = ia_i;
    v.ra0 = ra0_i; v.ra1 = ra1_i; v.rd0 = rd0_i; v.rd1 = rd1_i; v.rb = rb_i; v.cnt = cnt_i;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_strobes();
    we0 = 1'b0; we1 = 1'b0; iss_en = 1'b0; reset = 1'b0;
  endtask

  vec_t vecs [16];

  initial begin
    // rst we0 wa0 wd0  we1 wa1 wd1  iss ia  ra0 ra1  rd0 rd1 rbusy cnt
    vecs[0]  = mkv(1, 0, 0, 0,       0, 0, 0,       0, 0,  0,  5,  0,       0,       2'b00, 0);
    vecs[1]  = mkv(0, 1, 5, 'h1234,  0, 0, 0,       0, 0,  5,  0,  'h1234,  0,       2'b00, 0);
    vecs[2]  = mkv(0, 1, 0, 'hFFFF,  0, 0, 0,       0, 0,  0,  5,  0,       'h1234,  2'b00, 0);
    vecs[3]  = mkv(0, 1, 7, 'hAAAA,  1, 7, 'h5555,  0, 0,  7,  5,  'h5555,  'h1234,  2'b00, 0);
    vecs[4]  = mkv(0, 0, 0, 0,       0, 0, 0,       1, 3,  3,  4,  0,       0,       2'b01, 1);
    vecs[5]  = mkv(0, 0, 0, 0,       0, 0, 0,       1, 4,  3,  4,  0,       0,       2'b11, 2);
    vecs[6]  = mkv(0, 0, 0, 0,       0, 0, 0,       1, 9,  9,  4,  0,       0,       2'b11, 3);
    vecs[7]  = mkv(0, 1, 4, 'h11,    1, 4, 'h22,    0, 0,  4,  9,  'h22,    0,       2'b10, 2);
    vecs[8]  = mkv(0, 1, 6, 'h66,    0, 0, 0,       1, 6,  6,  3,  'h66,    0,       2'b11, 3);
    vecs[9]  = mkv(0, 0, 0, 0,       1, 5, 'h55,    0, 0,  5,  6,  'h55,    'h66,    2'b10, 3);
    vecs[10] = mkv(0, 1, 3, 'h33,    0, 0, 0,       1, 0,  3,  0,  'h33,    0,       2'b00, 2);
    vecs[11] = mkv(0, 1, 6, 'h6A,    0, 0, 0,       1, 9,  9,  6,  0,       'h6A,    2'b01, 1);
    vecs[12] = mkv(0, 1, 9, 'h90,    1, 9, 'h91,    1, 9,  9,  31, 'h91,    0,       2'b01, 1);
    vecs[13] = mkv(0, 0, 0, 0,       0, 0, 0,       1, 31, 31, 0,  0,       0,       2'b01, 2);
    vecs[14] = mkv(0, 0, 0, 0,       0, 0, 0,       1, 2,  2,  9,  0,       'h91,    2'b11, 3);
    vecs[15] = mkv(1, 1, 5, 'h77,    1, 7, 'h88,    1, 12, 5,  7,  0,       0,       2'b00, 0);

    reset = 1'b1; we0 = 1'b0; we1 = 1'b0; iss_en = 1'b0;
    wa0 = '0; wa1 = '0; wd0 = '0; wd1 = '0; iss_addr = '0; ra = '0;

    // Table: drive, clock once, drop strobes, then check stored state.
    for (int i = 0; i < 16; i++) begin
      reset = vecs[i].rst;
      we0 = vecs[i].we0; wa0 = vecs[i].wa0; wd0 = vecs[i].wd0;
      we1 = vecs[i].we1; wa1 = vecs[i].wa1; wd1 = vecs[i].wd1;
      iss_en = vecs[i].iss; iss_addr = vecs[i].ia;
      ra = {vecs[i].ra1, vecs[i].ra0};
      @(posedge clk);
      #1 idle_strobes();
      #1;
      chk($sformatf("v%0d_rd0", i), 64'(rd[31:0]), 64'(vecs[i].rd0));
      chk($sformatf("v%0d_rd1", i), 64'(rd[63:32]), 64'(vecs[i].rd1));
      chk($sformatf("v%0d_rbusy", i), 64'(rbusy), 64'(vecs[i].rb));
      chk($sformatf("v%0d_cnt", i), 64'(busy_cnt), 64'(vecs[i].cnt));
    end

    // Same-cycle read of a write in progress.
    we1 = 1'b1; wa1 = 5'd2; wd1 = 32'hBEEF; ra = {5'd2, 5'd0};
    #1;
`ifdef MULTIPORT_GRF_BYPASS_EN
    chk("byp_rd1_same", 64'(rd[63:32]), 64'h0000BEEF);
`else
    chk("byp_rd1_same", 64'(rd[63:32]), 64'h0);
`endif
    chk("byp_rbusy_same", 64'(rbusy), 64'h0);
    @(posedge clk);
    #1 idle_strobes();
    #1;
    chk("byp_rd1_next", 64'(rd[63:32]), 64'h0000BEEF);

    // Issue and write to the same register in one cycle, seen by a reader.
    we0 = 1'b1; wa0 = 5'd2; wd0 = 32'hCAFE; iss_en = 1'b1; iss_addr = 5'd2;
    #1;
`ifdef MULTIPORT_GRF_BYPASS_EN
    chk("iss_wr_rd1_same", 64'(rd[63:32]), 64'h0000CAFE);
    chk("iss_wr_rbusy_same", 64'(rbusy), 64'h2);
`else
    chk("iss_wr_rd1_same", 64'(rd[63:32]), 64'h0000BEEF);
    chk("iss_wr_rbusy_same", 64'(rbusy), 64'h0);
`endif
    @(posedge clk);
    #1 idle_strobes();
    #1;
    chk("iss_wr_rd1_next", 64'(rd[63:32]), 64'h0000CAFE);
    chk("iss_wr_rbusy_next", 64'(rbusy), 64'h2);
    chk("iss_wr_cnt", 64'(busy_cnt), 64'h1);

    // Reset held for several cycles while writes and issues keep coming.
    reset = 1'b1; we0 = 1'b1; wa0 = 5'd2; wd0 = 32'h1; we1 = 1'b1; wa1 = 5'd3; wd1 = 32'h2;
    iss_en = 1'b1; iss_addr = 5'd3; ra = {5'd3, 5'd2};
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("rsthold%0d_rd0", c), 64'(rd[31:0]), 64'h0);
      chk($sformatf("rsthold%0d_rd1", c), 64'(rd[63:32]), 64'h0);
      chk($sformatf("rsthold%0d_rbusy", c), 64'(rbusy), 64'h0);
      chk($sformatf("rsthold%0d_cnt", c), 64'(busy_cnt), 64'h0);
    end
    idle_strobes();
    @(posedge clk);
    #1;
    chk("post_rst_rd0", 64'(rd[31:0]), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
